// File: rtl/hyperram_arbiter_pkg.sv
// Shared defaults and sequencer state encoding for the HyperRAM front-end arbiter.
package hyperram_pkg;
    localparam int ADDR_W_DEF = 24;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        BUSY      = 3'd3,
        DONE      = 3'd4
    } state_t;
endpackage

// File: rtl/hyperram_arbiter_if.sv
// Requester and controller handshake bundle; slave = arbiter, master = requesters/controller.
interface hyperram_arbiter_if import hyperram_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              r0_req, r0_rdwr, r0_gnt, r0_next_wr, r0_rd_valid, r0_done, r0_err;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wr_data;
    logic              r1_req, r1_rdwr, r1_gnt, r1_next_wr, r1_rd_valid, r1_done, r1_err;
    logic [ADDR_W-1:0] r1_addr;
    logic [DATA_W-1:0] r1_wr_data;
    logic [DATA_W-1:0] rd_data, wr_data, mdata;
    logic [ADDR_W-1:0] addr;
    logic              start, rdwr, next_wr, mdata_ready, mbusy, arb_busy;

    modport slave (
        input  r0_req, r0_rdwr, r0_addr, r0_wr_data,
        input  r1_req, r1_rdwr, r1_addr, r1_wr_data,
        input  next_wr, mdata, mdata_ready, mbusy,
        output r0_gnt, r0_next_wr, r0_rd_valid, r0_done, r0_err,
        output r1_gnt, r1_next_wr, r1_rd_valid, r1_done, r1_err,
        output rd_data, start, rdwr, addr, wr_data, arb_busy
    );

    modport master (
        output r0_req, r0_rdwr, r0_addr, r0_wr_data,
        output r1_req, r1_rdwr, r1_addr, r1_wr_data,
        output next_wr, mdata, mdata_ready, mbusy,
        input  r0_gnt, r0_next_wr, r0_rd_valid, r0_done, r0_err,
        input  r1_gnt, r1_next_wr, r1_rd_valid, r1_done, r1_err,
        input  rd_data, start, rdwr, addr, wr_data, arb_busy
    );
endinterface

// File: rtl/hyperram_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the port that did not win last time goes next.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last : req1;
    end
endmodule

// File: rtl/hyperram_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing one HyperRAM controller.
module hyperram_arbiter import hyperram_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    hyperram_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nxt;
    logic              owner, last, err_flag, start_q, rdwr_q;
    logic              pick_valid, pick, timed_out;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] owner_wr;
    logic [CNT_W-1:0]  cnt;

    rr_arb2 u_pick (
        .req0   (bus.r0_req),
        .req1   (bus.r1_req),
        .last   (last),
        .valid  (pick_valid),
        .winner (pick)
    );

    assign timed_out = !bus.mbusy && (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_valid && !bus.mbusy) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (bus.mbusy) state_nxt = BUSY;
                       else if (timed_out) state_nxt = DONE;
            BUSY:      if (!bus.mbusy) state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // start is registered so it lands the cycle after gnt, once the command is stable
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            err_flag <= 1'b0;
            start_q  <= 1'b0;
            rdwr_q   <= 1'b0;
            addr_q   <= '0;
            cnt      <= '0;
        end else begin
            state   <= state_nxt;
            start_q <= (state == START);
            if (state == IDLE && state_nxt == START) begin
                owner  <= pick;
                last   <= pick;
                rdwr_q <= pick ? bus.r1_rdwr : bus.r0_rdwr;
                addr_q <= pick ? bus.r1_addr : bus.r0_addr;
            end
            if (state == START) begin
                cnt      <= '0;
                err_flag <= 1'b0;
            end else if (state == WAIT_BUSY) begin
                if (cnt != CNT_W'(TIMEOUT)) cnt <= cnt + CNT_W'(1);
                if (timed_out) err_flag <= 1'b1;
            end
        end
    end

    logic in_xfer, in_busy, in_done;
    assign in_xfer = (state == WAIT_BUSY) || (state == BUSY);
    assign in_busy = (state == BUSY);
    assign in_done = (state == DONE);
    assign owner_wr = owner ? bus.r1_wr_data : bus.r0_wr_data;

    assign bus.r0_gnt      = (state == START) && !owner;
    assign bus.r1_gnt      = (state == START) && owner;
    assign bus.r0_next_wr  = bus.next_wr && in_xfer && !owner;
    assign bus.r1_next_wr  = bus.next_wr && in_xfer && owner;
    assign bus.r0_rd_valid = bus.mdata_ready && in_busy && !owner;
    assign bus.r1_rd_valid = bus.mdata_ready && in_busy && owner;
    assign bus.r0_done     = in_done && !owner;
    assign bus.r1_done     = in_done && owner;
    assign bus.r0_err      = in_done && !owner && err_flag;
    assign bus.r1_err      = in_done && owner && err_flag;
    assign bus.rd_data     = bus.mdata;
    assign bus.start       = start_q;
    assign bus.rdwr        = rdwr_q;
    assign bus.addr        = addr_q;
    assign bus.wr_data     = (state == IDLE) ? '0 : owner_wr;
    assign bus.arb_busy    = (state != IDLE);
endmodule

// File: tb/tb_hyperram_arbiter.sv
// Directed scenarios plus random traffic, checked each cycle against a transaction-timeline model.
module tb_hyperram_arbiter;
    import hyperram_pkg::*;

    localparam int TO = 8;

    logic clk, rst;
    hyperram_arbiter_if #(.ADDR_W(24), .DATA_W(16)) bus ();

    hyperram_arbiter #(.ADDR_W(24), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;
    int n_nw0 = 0, n_nw1 = 0, n_rv0 = 0, n_rv1 = 0, n_done0 = 0, n_err0 = 0;
    int mc = 0, last_st = -1000, min_gap = 1000;
    bit gq[$];
    logic [15:0] rdq[$];

    function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, a, e, $time);
        end
    endfunction

    function automatic logic [12:0] ctl_of();
        return {bus.r1_gnt, bus.r0_gnt, bus.start, bus.r1_next_wr, bus.r0_next_wr,
                bus.r1_rd_valid, bus.r0_rd_valid, bus.r1_done, bus.r0_done,
                bus.r1_err, bus.r0_err, bus.arb_busy, bus.rdwr};
    endfunction

    // Model: each transaction is a timeline (grant cycle g, busy-from cycle, done cycle)
    bit mvalid = 0, act = 0, terr = 0, own = 0, lastw = 1, lrw = 0;
    int g = 0, bfrom = -1, dat = -1;
    logic [23:0] la = '0;

    always @(negedge clk) begin
        bit inwin, inbsy, dn, was_idle, w;
        logic [12:0] e_ctl;
        if (mvalid) begin
            inwin = act && mc >= g + 1 && (dat < 0 || mc < dat);
            inbsy = act && bfrom >= 0 && mc >= bfrom && (dat < 0 || mc < dat);
            dn    = act && mc == dat;
            e_ctl = {act && mc == g && own, act && mc == g && !own, act && mc == g + 1,
                     bus.next_wr && inwin && own, bus.next_wr && inwin && !own,
                     bus.mdata_ready && inbsy && own, bus.mdata_ready && inbsy && !own,
                     dn && own, dn && !own, dn && terr && own, dn && terr && !own, act, lrw};
            chk("ctl", ctl_of(), e_ctl);
            chk("addr", bus.addr, la);
            chk("wr_data", bus.wr_data, act ? (own ? bus.r1_wr_data : bus.r0_wr_data) : 16'h0);
            chk("rd_data", bus.rd_data, bus.mdata);
        end
        // observation counters for the directed checks
        if (bus.r0_next_wr === 1'b1) n_nw0++;
        if (bus.r1_next_wr === 1'b1) n_nw1++;
        if (bus.r0_rd_valid === 1'b1) n_rv0++;
        if (bus.r1_rd_valid === 1'b1) begin n_rv1++; rdq.push_back(bus.rd_data); end
        if (bus.r0_done === 1'b1) n_done0++;
        if (bus.r0_err === 1'b1) n_err0++;
        if (bus.r0_gnt === 1'b1) gq.push_back(1'b0);
        if (bus.r1_gnt === 1'b1) gq.push_back(1'b1);
        if (bus.start === 1'b1) begin
            if (mc - last_st < min_gap) min_gap = mc - last_st;
            last_st = mc;
        end
        if (rst) last_st = -1000;
        // advance the model with the inputs sampled at the coming edge
        was_idle = !act;
        if (act) begin
            if (mc == dat) act = 0;
            else if (dat < 0) begin
                if (bfrom < 0) begin
                    if (mc >= g + 1) begin
                        if (bus.mbusy) bfrom = mc + 1;
                        else if (mc == g + TO) begin dat = mc + 1; terr = 1; end
                    end
                end else if (mc >= bfrom && !bus.mbusy) dat = mc + 1;
            end
        end
        if (rst) begin
            act = 0; lastw = 1; own = 0; la = '0; lrw = 0; mvalid = 1;
        end else if (mvalid && was_idle && (bus.r0_req || bus.r1_req) && !bus.mbusy) begin
            w = (bus.r0_req && bus.r1_req) ? !lastw : bus.r1_req;
            act = 1; g = mc + 1; bfrom = -1; dat = -1; terr = 0;
            own = w; lastw = w;
            la  = w ? bus.r1_addr : bus.r0_addr;
            lrw = w ? bus.r1_rdwr : bus.r0_rdwr;
        end
        mc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input string nm);
        bit seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            seen = bus.start;
        end
        chk(nm, seen, 1);
    endtask

    // Controller stand-in; entered in the start cycle, returns in the DONE cycle.
    task automatic ctrl_txn(input int dly, input int blen, input int nwr, input int nrd);
        for (int i = 1; i <= dly + blen + 1; i++) begin
            step();
            bus.mbusy       = (i >= dly && i < dly + blen);
            bus.next_wr     = (i > dly && i <= dly + nwr);
            bus.mdata_ready = (i > dly && i <= dly + nrd);
            bus.mdata       = (i > dly && i <= dly + nrd) ? 16'(16'h1111 * (i - dly)) : 16'h0;
        end
    endtask

    initial begin
        int s0, s1, s2, s3, bs, be;
        rst = 1'b1;
        bus.r0_req = 0; bus.r0_rdwr = 0; bus.r0_addr = '0; bus.r0_wr_data = '0;
        bus.r1_req = 0; bus.r1_rdwr = 0; bus.r1_addr = '0; bus.r1_wr_data = '0;
        bus.next_wr = 0; bus.mdata_ready = 0; bus.mbusy = 0; bus.mdata = 16'hBEEF;
        step(); step();
        chk("rst_ctl", ctl_of(), 13'h0);
        chk("rst_addr", bus.addr, 24'h0);
        chk("rst_wr_data", bus.wr_data, 16'h0);
        chk("rst_rd_data", bus.rd_data, 16'hBEEF);
        rst = 1'b0;
        step();

        // both ports held: strict alternation starting with port 0
        bus.r0_req = 1; bus.r0_addr = 24'h000010;
        bus.r1_req = 1; bus.r1_addr = 24'h000020; bus.r1_rdwr = 1;
        s0 = gq.size();
        for (int k = 0; k < 4; k++) begin
            wait_start("t2_start");
            ctrl_txn(1, 2, 0, 0);
        end
        bus.r0_req = 0; bus.r1_req = 0;
        step(); step();
        chk("t2_count", gq.size() - s0, 4);
        for (int k = 0; k < 4 && s0 + k < gq.size(); k++) chk("t2_order", gq[s0 + k], k % 2);

        // r0 write with three next_wr pulses
        s0 = n_nw0; s1 = n_nw1; s2 = n_done0; s3 = n_err0;
        bus.r0_req = 1; bus.r0_rdwr = 0; bus.r0_addr = 24'h000123; bus.r0_wr_data = 16'hA5A5;
        step();
        chk("t1_gnt", {bus.r1_gnt, bus.r0_gnt}, 2'b01);
        step();
        chk("t1_start", bus.start, 1);
        chk("t1_addr", bus.addr, 24'h000123);
        chk("t1_wr_data", bus.wr_data, 16'hA5A5);
        ctrl_txn(3, 4, 3, 0);
        bus.r0_req = 0;
        step(); step();
        chk("t1_nw0", n_nw0 - s0, 3);
        chk("t1_nw1", n_nw1 - s1, 0);
        chk("t1_done", n_done0 - s2, 1);
        chk("t1_err", n_err0 - s3, 0);

        // r1 reads four words
        s0 = n_rv0; s1 = n_rv1; s2 = rdq.size();
        bus.r1_req = 1; bus.r1_rdwr = 1; bus.r1_addr = 24'h000400;
        wait_start("t3_start");
        chk("t3_rdwr", bus.rdwr, 1);
        ctrl_txn(2, 5, 0, 4);
        bus.r1_req = 0;
        step(); step();
        chk("t3_rv1", n_rv1 - s1, 4);
        chk("t3_rv0", n_rv0 - s0, 0);
        for (int k = 0; k < 4 && s2 + k < rdq.size(); k++)
            chk("t3_word", rdq[s2 + k], 64'(16'h1111 * (k + 1)));

        // timeout: mbusy never rises
        s0 = n_rv0;
        bus.r0_req = 1; bus.r0_rdwr = 1; bus.r0_addr = 24'h000777;
        wait_start("t4_start");
        for (int i = 1; i <= 9; i++) begin
            step();
            chk("t4_done_err", {bus.r0_done, bus.r0_err}, (i == 8) ? 2'b11 : 2'b00);
            bus.mdata_ready = (i == 3);
            if (i == 8) bus.r0_req = 0;
        end
        chk("t4_idle", bus.arb_busy, 0);
        step();
        chk("t4_rv0", n_rv0 - s0, 0);

        // reset in BUSY, controller still busy afterwards
        bus.r0_req = 1; bus.r0_rdwr = 0; bus.r0_addr = 24'h00BEEF;
        wait_start("t5_start");
        step(); bus.mbusy = 1;
        step(); step();
        chk("t5_busy", bus.arb_busy, 1);
        s2 = n_done0;
        rst = 1; step(); rst = 0;
        chk("t5_rst_ctl", ctl_of(), 13'h0);
        chk("t5_rst_addr", bus.addr, 24'h0);
        chk("t5_rst_wr_data", bus.wr_data, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_hold", {bus.r0_gnt, bus.start}, 2'b00);
        end
        bus.mbusy = 0;
        step();
        chk("t5_gnt", bus.r0_gnt, 1);
        wait_start("t5_start2");
        ctrl_txn(1, 1, 0, 0);
        bus.r0_req = 0;
        step();
        chk("t5_done_cnt", n_done0 - s2, 1);

        // idle mbusy blocks grants
        bus.mbusy = 1; bus.r1_req = 1; bus.r1_rdwr = 0; bus.r1_addr = 24'h00ABCD;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_hold", {bus.r1_gnt, bus.r0_gnt, bus.start}, 3'b000);
        end
        bus.mbusy = 0;
        step();
        chk("t6_gnt", bus.r1_gnt, 1);
        wait_start("t6_start");
        ctrl_txn(2, 3, 2, 2);
        bus.r1_req = 0;
        step();

        // random traffic
        bs = -1; be = -1;
        for (int t = 0; t < 3000; t++) begin
            step();
            if (bus.start) begin
                bs = t + int'($urandom_range(1, 10));
                be = bs + int'($urandom_range(1, 6));
            end
            rst             = ($urandom_range(0, 399) == 0);
            bus.mbusy       = (t >= bs && t < be) || ($urandom_range(0, 29) == 0);
            bus.next_wr     = ($urandom_range(0, 2) == 0);
            bus.mdata_ready = ($urandom_range(0, 2) == 0);
            bus.mdata       = 16'($urandom);
            if (!bus.r0_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.r0_req = 1; bus.r0_rdwr = 1'($urandom); bus.r0_addr = 24'($urandom);
                end
            end else if (bus.r0_done ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0))
                bus.r0_req = 0;
            if (!bus.r1_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.r1_req = 1; bus.r1_rdwr = 1'($urandom); bus.r1_addr = 24'($urandom);
                end
            end else if (bus.r1_done ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 49) == 0))
                bus.r1_req = 0;
            if ($urandom_range(0, 1) == 0) bus.r0_wr_data = 16'($urandom);
            if ($urandom_range(0, 1) == 0) bus.r1_wr_data = 16'($urandom);
        end
        rst = 0; bus.r0_req = 0; bus.r1_req = 0;
        bus.mbusy = 0; bus.next_wr = 0; bus.mdata_ready = 0;
        for (int i = 0; i < 20; i++) step();
        chk("idle_at_end", bus.arb_busy, 0);
        chk("min_start_gap_ok", min_gap >= 4, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its end, bad=%0d", bad);
        $fatal(1);
    end
endmodule

// File: doc/hyperram_arbiter.md
Name: hyperram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the HyperRAM controller. Typical requesters: serial command path (port 0) and a second master such as a video/test-pattern engine (port 1).
- Per transaction: latches the winner's command, issues a one-cycle start, tracks controller busy, and routes next_wr / read data to the owner only.
- Signals completion or timeout back to the owner.

Parameters:
- ADDR_W, 24, HyperRAM word address width.
- DATA_W, 16, data word width.
- TIMEOUT, 255, maximum cycles from start to mbusy rising before the transaction is aborted; minimum 1.

Ports:
- clk  in  1  system clock; the controller handshake signals are in this domain.
- rst  in  1  synchronous, active-high reset.
- r0_req  in  1  level request; held until r0_done.
- r0_rdwr  in  1  1=read, 0=write.
- r0_addr  in  ADDR_W  start address.
- r0_wr_data  in  DATA_W  current write word; requester advances it on r0_next_wr.
- r0_gnt  out  1  one-cycle pulse: command latched.
- r0_next_wr  out  1  controller next_wr, gated to owner.
- r0_rd_valid  out  1  mdata_ready, gated to owner.
- r0_done  out  1  one-cycle completion pulse.
- r0_err  out  1  one-cycle timeout pulse, coincident with r0_done.
- r1_*  same set as r0_*, for requester 1.
- rd_data  out  DATA_W  equals mdata; qualify with rX_rd_valid.
- start  out  1  one-cycle command strobe to controller.
- rdwr  out  1  latched direction.
- addr  out  ADDR_W  latched address.
- wr_data  out  DATA_W  owner's rX_wr_data, muxed combinationally.
- next_wr  in  1  controller requests next write word.
- mdata  in  DATA_W  controller read data.
- mdata_ready  in  1  read word valid.
- mbusy  in  1  controller busy.
- arb_busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE, owner=0, last=1 (port 0 wins first tie). All outputs 0 except rd_data, which follows mdata.
- States: IDLE, START, WAIT_BUSY, BUSY, DONE.
- IDLE -> START: on an edge where any req=1 and mbusy=0. While mbusy=1, no grant is issued.
  - Winner: if both request, the port != last; otherwise the single requester.
  - Same edge: owner<=winner, last<=winner, rdwr/addr latched from the winner, rX_gnt=1 for one cycle.
- START: start=1 for exactly one cycle; timeout counter cleared; -> WAIT_BUSY.
- WAIT_BUSY:
  - mbusy=1 -> BUSY.
  - Counter reaching TIMEOUT with mbusy still 0 -> DONE with error flag set.
- BUSY: stay while mbusy=1. mbusy=0 -> DONE.
- DONE: owner's done=1 for one cycle (err=1 as well on timeout), then -> IDLE.
  - Owner may drop req in the same cycle; a req still high in IDLE is a new request.
  - Minimum gap between consecutive start pulses is 4 cycles.
- Latency: req high at edge N -> gnt during cycle N+1, start during cycle N+2.
- Routing:
  - rX_next_wr = next_wr & (owner==X) & state in {WAIT_BUSY, BUSY}.
  - rX_rd_valid = mdata_ready & (owner==X) & state==BUSY.
  - next_wr or mdata_ready in any other state: ignored, no output.
- wr_data tracks the owner's wr_data input in every state except IDLE; 0 in IDLE.
- Requester drops req mid-transaction: the transaction completes and done still pulses. The arbiter cannot cancel the controller.
- Both requests present continuously: grants strictly alternate 0,1,0,1.
- Reset mid-transaction: back to IDLE immediately, no done pulse. The controller is not reset by this block; a new grant waits for mbusy=0.
- Timeout counter: width clog2(TIMEOUT+1), saturating, no wrap.

Decomposition:
- Shared package hyperram_pkg: ADDR_W/DATA_W defaults and the state encoding constants (IDLE=0, START=1, WAIT_BUSY=2, BUSY=3, DONE=4).
- Optional sub-module rr_arb2: 2-way round-robin pick from (req0, req1, last) -> (valid, winner). Everything else stays flat.

Test Plan:
- r0 write: r0_req=1, rdwr=0, addr=0x000123, wr_data=0xA5A5; controller model raises mbusy 3 cycles after start and pulses next_wr 3 times -> gnt at N+1, start at N+2, addr=0x000123, r0_next_wr pulses 3 times, r1_next_wr stays 0, r0_done once after mbusy falls, r0_err=0.
- Simultaneous r0 and r1 requests held for 4 transactions -> gnt order r0, r1, r0, r1; start pulses at least 4 cycles apart.
- r1 read of 4 words, model returns 0x1111..0x4444 on mdata_ready -> r1_rd_valid pulses 4 times with matching rd_data; r0_rd_valid stays 0.
- Timeout: TIMEOUT=8, mbusy held 0 after start -> r0_done and r0_err pulse together 8 cycles after WAIT_BUSY entry, then IDLE; stray mdata_ready meanwhile gives no rd_valid.
- Reset during BUSY -> all outputs 0 next cycle, no done. With mbusy still 1 and r0_req=1, no gnt until mbusy falls; then gnt to r0.
- mbusy=1 at idle with r1_req=1 for 10 cycles -> no gnt and no start; gnt the cycle after mbusy=0 is sampled.
